// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-port codes and arbiter state encoding.
// Used by the arbiter and its lane alignment helper.
package mem_port_arbiter_pkg;

  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_LS,
    RESP
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane steering: write enables, store replication,
// load extract/extend and misalignment detection.
module lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  lo_i,
  input  logic [1:0]  size_i,
  input  logic        wr_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wen_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        mis_o
);

  logic [3:0]  wen_b;
  logic [31:0] sh;
  logic [15:0] half;

  assign sh   = rdata_i >> {lo_i, 3'b000};
  assign half = lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Size decode; code 2'b11 behaves as a word access
  always_comb begin
    wen_b   = 4'b1111;
    wdata_o = wdata_i;
    load_o  = rdata_i;
    mis_o   = 1'b0;
    unique case (1'b1)
      (size_i == MEM_BYTE): begin
        wen_b   = 4'b0001 << lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        load_o  = uns_i ? {24'h0, sh[7:0]}
                        : {{24{sh[7]}}, sh[7:0]};
      end
      (size_i == MEM_HALF): begin
        wen_b   = 4'b0011 << {lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        load_o  = uns_i ? {16'h0, half}
                        : {{16{half[15]}}, half};
        mis_o   = lo_i[0];
      end
      default: begin
        mis_o = |lo_i;
      end
    endcase
    wen_o = wr_i ? wen_b : 4'b0000;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and LS onto one SRAM port with
// wait-state handshake and anti-starvation for IF.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        ls_req,
  input  logic [4:0]  ls_op,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_ack,
  output logic        ls_err,
  output logic        mem_cs,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wen,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  arb_state_e  state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic        cs_q, cs_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  wen_q, wen_d;
  logic        ifa_q, ifa_d;
  logic        lsa_q, lsa_d;
  logic        err_q, err_d;
  logic [31:0] ifr_q, ifr_d;
  logic [31:0] lsr_q, lsr_d;
  logic [1:0]  lo_q, lo_d;
  logic [1:0]  sz_q, sz_d;
  logic        uns_q, uns_d;

  logic        idle;
  logic [1:0]  la_lo, la_sz;
  logic        la_uns, la_mis;
  logic [3:0]  la_wen;
  logic [31:0] la_wdat, la_load;
  logic        unused_if_lo;

  assign unused_if_lo = ^if_addr[1:0];
  assign idle   = (state_q == IDLE);
  assign la_lo  = idle ? ls_addr[1:0] : lo_q;
  assign la_sz  = idle ? ls_op[1:0]   : sz_q;
  assign la_uns = idle ? ls_op[2]     : uns_q;

  lane_align u_align (
    .lo_i    (la_lo),
    .size_i  (la_sz),
    .wr_i    (ls_op[4:3] == MEM_WRITE),
    .uns_i   (la_uns),
    .wdata_i (ls_wdata),
    .rdata_i (mem_rdata),
    .wen_o   (la_wen),
    .wdata_o (la_wdat),
    .load_o  (la_load),
    .mis_o   (la_mis)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      cs_q     <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
      wen_q    <= '0;
      ifa_q    <= 1'b0;
      lsa_q    <= 1'b0;
      err_q    <= 1'b0;
      ifr_q    <= '0;
      lsr_q    <= '0;
      lo_q     <= '0;
      sz_q     <= '0;
      uns_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      cs_q     <= cs_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      wen_q    <= wen_d;
      ifa_q    <= ifa_d;
      lsa_q    <= lsa_d;
      err_q    <= err_d;
      ifr_q    <= ifr_d;
      lsr_q    <= lsr_d;
      lo_q     <= lo_d;
      sz_q     <= sz_d;
      uns_q    <= uns_d;
    end
  end

  // Arbitration, memory sequencing and response generation
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    cs_d     = cs_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    wen_d    = wen_q;
    ifa_d    = 1'b0;
    lsa_d    = 1'b0;
    err_d    = 1'b0;
    ifr_d    = ifr_q;
    lsr_d    = lsr_q;
    lo_d     = lo_q;
    sz_d     = sz_q;
    uns_d    = uns_q;
    unique case (state_q)
      IDLE: begin
        if (!if_req) starve_d = '0;
        if (ls_req && !(if_req && starve_q == SMAX)) begin
          if (if_req && starve_q != SMAX)
            starve_d = starve_q + 1'b1;
          lo_d  = ls_addr[1:0];
          sz_d  = ls_op[1:0];
          uns_d = ls_op[2];
          if (la_mis) begin
            state_d = RESP;
            lsa_d   = 1'b1;
            err_d   = 1'b1;
            lsr_d   = '0;
          end else begin
            state_d = BUSY_LS;
            cs_d    = 1'b1;
            addr_d  = {ls_addr[31:2], 2'b00};
            wdat_d  = la_wdat;
            wen_d   = la_wen;
          end
        end else if (if_req) begin
          starve_d = '0;
          state_d  = BUSY_IF;
          cs_d     = 1'b1;
          addr_d   = {if_addr[31:2], 2'b00};
          wdat_d   = '0;
          wen_d    = '0;
        end
      end
      BUSY_IF: begin
        if (mem_ready) begin
          state_d = RESP;
          cs_d    = 1'b0;
          wen_d   = '0;
          ifr_d   = mem_rdata;
          ifa_d   = 1'b1;
        end
      end
      BUSY_LS: begin
        if (mem_ready) begin
          state_d = RESP;
          cs_d    = 1'b0;
          wen_d   = '0;
          lsr_d   = la_load;
          lsa_d   = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase
  end

  assign if_rdata  = ifr_q;
  assign if_ack    = ifa_q;
  assign ls_rdata  = lsr_q;
  assign ls_ack    = lsa_q;
  assign ls_err    = err_q;
  assign mem_cs    = cs_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdat_q;
  assign mem_wen   = wen_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Expected values are hand-computed constants.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        ls_req;
  logic [4:0]  ls_op;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_ack;
  logic        ls_err;
  logic        mem_cs;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wen;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;
  int n;

  localparam logic [4:0] SB  = 5'b10_0_00;
  localparam logic [4:0] SH  = 5'b10_0_01;
  localparam logic [4:0] SW  = 5'b10_0_10;
  localparam logic [4:0] LB  = 5'b01_0_00;
  localparam logic [4:0] LH  = 5'b01_0_01;
  localparam logic [4:0] LHU = 5'b01_1_01;
  localparam logic [4:0] LW  = 5'b01_0_10;

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .ls_req    (ls_req),
    .ls_op     (ls_op),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_rdata  (ls_rdata),
    .ls_ack    (ls_ack),
    .ls_err    (ls_err),
    .mem_cs    (mem_cs),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ls_go(input logic [4:0] op,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [31:0] rd);
    ls_op     = op;
    ls_addr   = a;
    ls_wdata  = wd;
    mem_rdata = rd;
    mem_ready = 1'b1;
    ls_req    = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_op = '0;
    ls_addr = '0; ls_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    tick(); tick();
    chk("rst_ctl", {25'h0, mem_cs, mem_wen, if_ack,
                    ls_ack, ls_err}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_ifr", if_rdata, 32'h0);
    chk("rst_lsr", ls_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // IF fetch, zero-wait
    if_req = 1'b1; if_addr = 32'h102;
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    chk("if_n_cs", mem_cs, 1'b0);
    tick();
    chk("if_n1_cs", mem_cs, 1'b1);
    chk("if_n1_addr", mem_addr, 32'h100);
    chk("if_n1_wen", mem_wen, 4'h0);
    tick();
    chk("if_n2_ack", {if_ack, ls_ack, mem_cs}, 3'b100);
    chk("if_rdata", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    tick();
    chk("if_n3_ack", if_ack, 1'b0);

    // SB
    ls_go(SB, 32'h203, 32'h000000A5, 32'h0);
    tick();
    chk("sb_addr", mem_addr, 32'h200);
    chk("sb_wen", mem_wen, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    tick();
    chk("sb_ack", {ls_ack, ls_err, if_ack}, 3'b100);
    ls_req = 1'b0;
    tick();

    // SH
    ls_go(SH, 32'h202, 32'hFFFF1234, 32'h0);
    tick();
    chk("sh_wen", mem_wen, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    tick(); ls_req = 1'b0; tick();

    // LH signed
    ls_go(LH, 32'h202, 32'h0, 32'h80010000);
    tick();
    chk("lh_wen", mem_wen, 4'b0000);
    tick();
    chk("lh_ack", ls_ack, 1'b1);
    chk("lh_data", ls_rdata, 32'hFFFF8001);
    ls_req = 1'b0; tick();

    // LHU
    ls_go(LHU, 32'h202, 32'h0, 32'h80010000);
    tick(); tick();
    chk("lhu_data", ls_rdata, 32'h00008001);
    ls_req = 1'b0; tick();

    // LB signed, lane 1
    ls_go(LB, 32'h201, 32'h0, 32'h00008000);
    tick(); tick();
    chk("lb_data", ls_rdata, 32'hFFFFFF80);
    ls_req = 1'b0; tick();

    // Misaligned LW
    ls_go(LW, 32'h106, 32'h0, 32'h12345678);
    tick();
    chk("mis_cs", mem_cs, 1'b0);
    chk("mis_ack", {ls_ack, ls_err}, 2'b11);
    chk("mis_data", ls_rdata, 32'h0);
    ls_req = 1'b0;
    tick();
    chk("mis_after", {ls_ack, ls_err, mem_cs}, 3'b000);

    // Continuous contention: LS x4 then IF
    if_req = 1'b1; if_addr = 32'h500;
    ls_go(LW, 32'h400, 32'h0, 32'h0);
    for (int g = 0; g < 10; g++) begin
      n = 0;
      while (!(if_ack || ls_ack) && n < 8) begin
        tick();
        n++;
      end
      chk($sformatf("arb%0d_lat", g), n, 2);
      chk($sformatf("arb%0d_if", g), {if_ack, ls_ack},
          (g % 5 == 4) ? 2'b10 : 2'b01);
      tick();
    end
    if_req = 1'b0; ls_req = 1'b0;
    tick(); tick();

    // Wait states: ready low 3 cycles
    ls_go(SW, 32'h300, 32'h11223344, 32'h0);
    mem_ready = 1'b0;
    tick();
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("ws%0d_hold", w), {mem_cs, mem_wen,
          mem_addr[11:0]}, {1'b1, 4'hF, 12'h300});
      chk($sformatf("ws%0d_noack", w), ls_ack, 1'b0);
      if (w == 3) mem_ready = 1'b1;
      tick();
    end
    chk("ws_ack", ls_ack, 1'b1);
    chk("ws_wdata", mem_wdata, 32'h11223344);
    ls_req = 1'b0;
    tick();
    chk("ws_single", ls_ack, 1'b0);

    // Reset during a wait state
    ls_go(LW, 32'h340, 32'h0, 32'h0);
    mem_ready = 1'b0;
    tick();
    chk("rm_busy", mem_cs, 1'b1);
    tick();
    rst = 1'b1;
    ls_req = 1'b0;
    tick();
    chk("rm_ctl", {mem_cs, mem_wen, ls_ack, ls_err}, 7'h0);
    chk("rm_addr", mem_addr, 32'h0);
    rst = 1'b0;
    mem_ready = 1'b1;
    tick();
    chk("rm_noack", {ls_ack, if_ack, mem_cs}, 3'b000);
    tick();
    chk("rm_noack2", {ls_ack, if_ack}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
